// File: rtl/muldiv_sequencer.sv
// Request sequencer for the HI/LO MulDiv core: expands MULT/DIV/LOAD/READ into F-code steps
// and reads HI then LO back. Define MULDIV_SEQ_DZ_TRAP_EN to short-circuit DIV-by-zero to DONE.
module muldiv_sequencer #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] opa,
    input  logic [N-1:0] opb,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] res_hi,
    output logic [N-1:0] res_lo,
    output logic         dz,
    output logic [N-1:0] md_a,
    output logic [N-1:0] md_b,
    output logic [3:0]   md_F,
    input  logic [N-1:0] md_y
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR1, S_WR2, S_RD_HI, S_RD_LO, S_DONE
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    localparam logic [3:0] F_VIEW_HI = 4'b0000;
    localparam logic [3:0] F_WR_HI   = 4'b0001;
    localparam logic [3:0] F_VIEW_LO = 4'b0010;
    localparam logic [3:0] F_WR_LO   = 4'b0011;
    localparam logic [3:0] F_MULT    = 4'b1000;
    localparam logic [3:0] F_DIV     = 4'b1010;

    state_t       state_reg, state_next;
    logic [1:0]   op_reg;
    logic [N-1:0] opa_reg, opb_reg;
    logic [N-1:0] res_hi_reg, res_lo_reg;
    logic         dz_reg;
    logic         accept;
    logic         div_zero;
    logic         dz_trap;

    assign accept   = (state_reg == S_IDLE) && start;
    assign div_zero = (op == OP_DIV) && (opb == '0);

`ifdef MULDIV_SEQ_DZ_TRAP_EN
    assign dz_trap = div_zero;
`else
    assign dz_trap = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        md_F       = F_VIEW_HI;
        md_a       = opa_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_READ)
                        state_next = S_RD_HI;
                    else if (dz_trap)
                        state_next = S_DONE;
                    else
                        state_next = S_WR1;
                end
            end
            S_WR1: begin
                case (op_reg)
                    OP_MULT: md_F = F_MULT;
                    OP_DIV:  md_F = F_DIV;
                    OP_LOAD: md_F = F_WR_HI;
                    default: md_F = F_VIEW_HI;
                endcase
                state_next = (op_reg == OP_LOAD) ? S_WR2 : S_RD_HI;
            end
            S_WR2: begin
                // LO is loaded through the core's a port, so opb is steered there
                md_F       = F_WR_LO;
                md_a       = opb_reg;
                state_next = S_RD_HI;
            end
            S_RD_HI: begin
                md_F       = F_VIEW_HI;
                state_next = S_RD_LO;
            end
            S_RD_LO: begin
                md_F       = F_VIEW_LO;
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            op_reg     <= OP_MULT;
            opa_reg    <= '0;
            opb_reg    <= '0;
            res_hi_reg <= '0;
            res_lo_reg <= '0;
            dz_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg  <= op;
                opa_reg <= opa;
                opb_reg <= opb;
                dz_reg  <= div_zero;
                if (dz_trap) begin
                    res_hi_reg <= '0;
                    res_lo_reg <= '0;
                end
            end
            if (state_reg == S_RD_HI)
                res_hi_reg <= md_y;
            if (state_reg == S_RD_LO)
                res_lo_reg <= md_y;
        end
    end

    assign busy   = (state_reg != S_IDLE);
    assign done   = (state_reg == S_DONE);
    assign res_hi = res_hi_reg;
    assign res_lo = res_lo_reg;
    assign dz     = dz_reg;
    assign md_b   = opb_reg;

endmodule
